// File: rtl/if_id_stage.sv
// ---------------------------------------------------------------------------
// if_id_stage
//
// Instruction-fetch stage and IF/ID pipeline register of a 5-stage MIPS
// pipeline. Owns the program counter, drives the instruction-memory address,
// selects the next PC and latches the fetched word for the decode stage.
//
// Ports:
//   clk            in   1   rising-edge clock
//   rst_n          in   1   asynchronous reset, active low
//   imem_addr      out  32  instruction-memory byte address (the PC register)
//   imem_rdata     in   32  instruction word read combinationally at imem_addr
//   stall          in   1   hold the PC and the IF/ID register
//   branch_taken   in   1   taken branch resolved in ID
//   branch_target  in   32  branch target address
//   jump           in   1   j/jal/jr resolved in ID
//   jump_target    in   32  jump target address
//   exc_redirect   in   1   exception/interrupt: go to EXC_VECTOR and flush
//   halt_req       in   1   enter HALTED at the next clock edge
//   id_instr       out  32  registered instruction for ID
//   id_pc_plus4    out  32  registered PC+4 of id_instr
//   id_valid       out  1   id_instr is a real instruction (0 = bubble)
//   halted         out  1   fetch is halted until reset
// ---------------------------------------------------------------------------
module if_id_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
    parameter bit          DELAY_SLOT = 1'b1,
    parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        exc_redirect,
    input  logic        halt_req,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc_plus4,
    output logic        id_valid,
    output logic        halted
);

    // -----------------------------------------------------------------------
    // Types
    // -----------------------------------------------------------------------
    typedef enum logic [0:0] {
        StRun,
        StHalted
    } state_e;

    // Source of the next PC value.
    typedef enum logic [2:0] {
        PcHold,
        PcSeq,
        PcBranch,
        PcJump,
        PcExc
    } pc_sel_e;

    // What the IF/ID register does at the next edge.
    typedef enum logic [1:0] {
        IdHold,
        IdLoad,
        IdBubble
    } id_op_e;

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic [31:0] id_pc_plus4_q, id_pc_plus4_d;
    logic        id_valid_q, id_valid_d;

    pc_sel_e     pc_sel;
    id_op_e      id_op;

    logic [31:0] pc_plus4;
    logic [31:0] branch_aligned;
    logic [31:0] jump_aligned;
    logic        redirect;

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun: begin
                // An exception in the same cycle keeps the core running so the
                // handler actually gets fetched.
                if (halt_req && !exc_redirect) begin
                    state_d = StHalted;
                end
            end
            StHalted: begin
                state_d = StHalted;
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: output / control decode
    // -----------------------------------------------------------------------
    always_comb begin
        pc_sel = PcSeq;
        id_op  = IdLoad;
        halted = 1'b0;
        // jump and branch are both ignored while stalled, so the redirect only
        // counts when the stall is absent.
        redirect = (jump || branch_taken) && !stall;

        unique case (state_q)
            StRun: begin
                if (exc_redirect) begin
                    pc_sel = PcExc;
                    id_op  = IdBubble;
                end else if (stall) begin
                    pc_sel = PcHold;
                    id_op  = IdHold;
                end else if (jump) begin
                    pc_sel = PcJump;
                    id_op  = DELAY_SLOT ? IdLoad : IdBubble;
                end else if (branch_taken) begin
                    pc_sel = PcBranch;
                    id_op  = DELAY_SLOT ? IdLoad : IdBubble;
                end else begin
                    pc_sel = PcSeq;
                    id_op  = IdLoad;
                end
            end
            StHalted: begin
                pc_sel   = PcHold;
                id_op    = IdBubble;
                halted   = 1'b1;
                redirect = 1'b0;
            end
            default: begin
                pc_sel = PcHold;
                id_op  = IdBubble;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Address arithmetic
    // -----------------------------------------------------------------------
    // Targets are word aligned by clearing the two byte-offset bits; the
    // masking form keeps every input bit referenced.
    assign branch_aligned = branch_target & 32'hFFFF_FFFC;
    assign jump_aligned   = jump_target & 32'hFFFF_FFFC;

    // Wraps modulo 2^32: 32'hFFFF_FFFC + 4 = 0.
    assign pc_plus4 = pc_q + 32'd4;

    // -----------------------------------------------------------------------
    // Next-PC and IF/ID next-state
    // -----------------------------------------------------------------------
    always_comb begin
        pc_d = pc_q;
        unique case (pc_sel)
            PcHold:   pc_d = pc_q;
            PcSeq:    pc_d = pc_plus4;
            PcBranch: pc_d = branch_aligned;
            PcJump:   pc_d = jump_aligned;
            PcExc:    pc_d = EXC_VECTOR;
            default:  pc_d = pc_q;
        endcase
    end

    always_comb begin
        id_instr_d    = id_instr_q;
        id_pc_plus4_d = id_pc_plus4_q;
        id_valid_d    = id_valid_q;
        unique case (id_op)
            IdHold: begin
                id_instr_d    = id_instr_q;
                id_pc_plus4_d = id_pc_plus4_q;
                id_valid_d    = id_valid_q;
            end
            IdLoad: begin
                id_instr_d    = imem_rdata;
                id_pc_plus4_d = pc_plus4;
                id_valid_d    = 1'b1;
            end
            IdBubble: begin
                id_instr_d    = NOP_WORD;
                id_pc_plus4_d = 32'd0;
                id_valid_d    = 1'b0;
            end
            default: begin
                id_instr_d    = NOP_WORD;
                id_pc_plus4_d = 32'd0;
                id_valid_d    = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            id_instr_q    <= NOP_WORD;
            id_pc_plus4_q <= 32'd0;
            id_valid_q    <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            id_instr_q    <= id_instr_d;
            id_pc_plus4_q <= id_pc_plus4_d;
            id_valid_q    <= id_valid_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs: all registered, so nothing combinational reaches id_* or
    // imem_addr from the inputs.
    // -----------------------------------------------------------------------
    assign imem_addr   = pc_q;
    assign id_instr    = id_instr_q;
    assign id_pc_plus4 = id_pc_plus4_q;
    assign id_valid    = id_valid_q;

    // redirect is a decode convenience for the control block; it carries no
    // state of its own.
    logic unused_redirect;
    assign unused_redirect = redirect;

endmodule

// File: tb/tb_if_id_stage.sv
module tb_if_id_stage;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, branch_taken, jump, exc_redirect, halt_req;
    logic [31:0] branch_target, jump_target;

    // Instance A: delay slot kept. Instance B: delay slot squashed.
    logic [31:0] addr_a, rdata_a, instr_a, pc4_a;
    logic        valid_a, halted_a;
    logic [31:0] addr_b, rdata_b, instr_b, pc4_b;
    logic        valid_b, halted_b;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // Instruction memory contents: a fixed, address-dependent pattern.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000 ^ {a[15:0], a[31:16]};
    endfunction

    assign rdata_a = mem_word(addr_a);
    assign rdata_b = mem_word(addr_b);

    if_id_stage #(.DELAY_SLOT(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .imem_addr(addr_a), .imem_rdata(rdata_a),
        .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target), .exc_redirect(exc_redirect),
        .halt_req(halt_req), .id_instr(instr_a), .id_pc_plus4(pc4_a),
        .id_valid(valid_a), .halted(halted_a)
    );

    if_id_stage #(.DELAY_SLOT(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .imem_addr(addr_b), .imem_rdata(rdata_b),
        .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target), .exc_redirect(exc_redirect),
        .halt_req(halt_req), .id_instr(instr_b), .id_pc_plus4(pc4_b),
        .id_valid(valid_b), .halted(halted_b)
    );

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic        chk_id;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        va;
        logic        vb;
        logic        halted;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        stall = 0; branch_taken = 0; jump = 0; exc_redirect = 0; halt_req = 0;
        branch_target = 32'h0; jump_target = 32'h0;
    endtask

    task automatic push(input string tag, input logic [31:0] pc, input logic chk_id,
                        input logic [31:0] instr, input logic [31:0] pc4,
                        input logic va, input logic vb, input logic hlt);
        exp_t e;
        e.tag = tag; e.pc = pc; e.chk_id = chk_id; e.instr = instr; e.pc4 = pc4;
        e.va = va; e.vb = vb; e.halted = hlt;
        exp_q.push_back(e);
    endtask

    // Advance one clock and compare both instances against the oldest entry.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL scoreboard: observed empty queue expected an entry");
            return;
        end
        e = exp_q.pop_front();
        chk({e.tag, "/pc_a"}, addr_a, e.pc);
        chk({e.tag, "/pc_b"}, addr_b, e.pc);
        chk({e.tag, "/halted_a"}, {31'd0, halted_a}, {31'd0, e.halted});
        chk({e.tag, "/halted_b"}, {31'd0, halted_b}, {31'd0, e.halted});
        if (e.chk_id) begin
            chk({e.tag, "/valid_a"}, {31'd0, valid_a}, {31'd0, e.va});
            chk({e.tag, "/instr_a"}, instr_a, e.va ? e.instr : NOP);
            if (e.va) chk({e.tag, "/pc4_a"}, pc4_a, e.pc4);
            chk({e.tag, "/valid_b"}, {31'd0, valid_b}, {31'd0, e.vb});
            chk({e.tag, "/instr_b"}, instr_b, e.vb ? e.instr : NOP);
            if (e.vb) chk({e.tag, "/pc4_b"}, pc4_b, e.pc4);
        end
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        #12;
        // Reset values.
        chk("rst/pc", addr_a, 32'h0000_3000);
        chk("rst/instr", instr_a, NOP);
        chk("rst/pc4", pc4_a, 32'h0);
        chk("rst/valid", {31'd0, valid_a}, 32'd0);
        chk("rst/halted", {31'd0, halted_a}, 32'd0);
        chk("rst/valid_b", {31'd0, valid_b}, 32'd0);
        rst_n = 1'b1;

        // Sequential fetch.
        push("seq0", 32'h3004, 1, mem_word(32'h3000), 32'h3004, 1, 1, 0); tick();
        push("seq1", 32'h3008, 1, mem_word(32'h3004), 32'h3008, 1, 1, 0); tick();
        push("seq2", 32'h300C, 1, mem_word(32'h3008), 32'h300C, 1, 1, 0); tick();

        // Stall for three cycles at 300C.
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            push("stall", 32'h300C, 1, mem_word(32'h3008), 32'h300C, 1, 1, 0); tick();
        end
        stall = 0;
        push("resume", 32'h3010, 1, mem_word(32'h300C), 32'h3010, 1, 1, 0); tick();

        // Taken branch with a misaligned target: delay slot kept in A, bubble in B.
        branch_taken = 1; branch_target = 32'h3041;
        push("branch", 32'h3040, 1, mem_word(32'h3010), 32'h3014, 1, 0, 0); tick();
        idle();
        push("br_tgt", 32'h3044, 1, mem_word(32'h3040), 32'h3044, 1, 1, 0); tick();

        // jump and branch together: jump wins.
        jump = 1; jump_target = 32'h5000; branch_taken = 1; branch_target = 32'h6000;
        push("jmp_br", 32'h5000, 1, mem_word(32'h3044), 32'h3048, 1, 0, 0); tick();

        // jump under stall is ignored and IF/ID holds.
        stall = 1; jump = 1; jump_target = 32'h7000; branch_taken = 0;
        push("jmp_stall", 32'h5000, 1, mem_word(32'h3044), 32'h3048, 1, 0, 0); tick();

        // Exception beats stall and jump.
        exc_redirect = 1;
        push("exc", 32'h4180, 1, NOP, 32'h0, 0, 0, 0); tick();
        idle();
        push("exc_seq", 32'h4184, 1, mem_word(32'h4180), 32'h4184, 1, 1, 0); tick();

        // PC wrap-around at the top of the address space.
        jump = 1; jump_target = 32'hFFFF_FFFF;
        push("to_top", 32'hFFFF_FFFC, 1, mem_word(32'h4184), 32'h4188, 1, 0, 0); tick();
        idle();
        push("wrap", 32'h0000_0000, 1, mem_word(32'hFFFF_FFFC), 32'h0, 1, 1, 0); tick();
        push("post_wrap", 32'h0000_0004, 1, mem_word(32'h0), 32'h4, 1, 1, 0); tick();

        // halt_req with exc_redirect: exception wins, no halt.
        halt_req = 1; exc_redirect = 1;
        push("halt_exc", 32'h4180, 1, NOP, 32'h0, 0, 0, 0); tick();
        idle();
        push("pre_halt", 32'h4184, 1, mem_word(32'h4180), 32'h4184, 1, 1, 0); tick();

        // Halt (stalled on that edge so the PC holds either way).
        halt_req = 1; stall = 1;
        push("halt", 32'h4184, 0, NOP, 32'h0, 0, 0, 1); tick();
        idle();
        jump = 1; jump_target = 32'h8000;
        push("halted0", 32'h4184, 1, NOP, 32'h0, 0, 0, 1); tick();
        idle();
        push("halted1", 32'h4184, 1, NOP, 32'h0, 0, 0, 1); tick();

        // Reset asserted mid-cycle takes effect without a clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        chk("async/pc", addr_a, 32'h0000_3000);
        chk("async/instr", instr_a, NOP);
        chk("async/pc4", pc4_a, 32'h0);
        chk("async/valid", {31'd0, valid_a}, 32'd0);
        chk("async/halted", {31'd0, halted_a}, 32'd0);
        #2;
        rst_n = 1'b1;
        push("after_rst", 32'h3004, 1, mem_word(32'h3000), 32'h3004, 1, 1, 0); tick();

        chk("queue_empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
